saturn_bus_arbiter: RTL and testbench

//  Sequences and shares saturn_bus_ctrl between three requesters: system (RESET/CONFIGURE), data (DP read/write) and fetch (LOAD_PC).

---
 rtl/saturn_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_saturn_bus_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/saturn_bus_arbiter.sv
// saturn_bus_arbiter: grants saturn_bus_ctrl to sys > data > fetch and sequences its command levels.
// Optional watchdog under SATURN_BUS_ARB_TIMEOUT_EN forces IDLE and sets o_err after TIMEOUT ticks.
module saturn_bus_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en_bus_ecmd,
  input  logic              i_stalled,
  input  logic              i_stalled_by_bus,
  input  logic              i_sys_req,
  input  logic              i_sys_op,
  input  logic [ADDR_W-1:0] i_sys_addr,
  output logic              o_sys_gnt,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [LEN_W-1:0]  i_data_len,
  output logic              o_data_gnt,
  output logic              o_data_done,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_gnt,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_load_pc,
  output logic              o_cmd_load_dp,
  output logic              o_cmd_dp_write,
  output logic              o_cmd_config,
  output logic              o_cmd_reset,
  output logic              o_busy,
  output logic [1:0]        o_owner,
  output logic              o_err
);
  typedef enum logic [1:0] {IDLE, ADDR, XFER, RESTORE} state_t;
  state_t             state_q;
  logic [2:0]         addr_cnt_q;
  logic [LEN_W-1:0]   xfer_cnt_q, len_q;
  logic               we_q, sys_gnt_q, data_gnt_q, fetch_gnt_q, done_q, err_q;
  logic               load_pc_q, load_dp_q, dp_write_q, config_q, reset_q;
  logic [1:0]         owner_q;
  logic [ADDR_W-1:0]  address_q;
  logic               tick, wd_hit;
  assign tick = i_en_bus_ecmd && !i_stalled;
`ifdef SATURN_BUS_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  assign wd_hit = tick && state_q != IDLE && wd_q == WD_W'(TIMEOUT - 1);
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) wd_q <= '0;
    else if (state_q == IDLE || wd_hit) wd_q <= '0;
    else if (tick) wd_q <= wd_q + 1'b1;
`else
  assign wd_hit = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      addr_cnt_q  <= '0;
      xfer_cnt_q  <= '0;
      len_q       <= '0;
      we_q        <= 1'b0;
      sys_gnt_q   <= 1'b0;
      data_gnt_q  <= 1'b0;
      fetch_gnt_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_pc_q   <= 1'b0;
      load_dp_q   <= 1'b0;
      dp_write_q  <= 1'b0;
      config_q    <= 1'b0;
      reset_q     <= 1'b0;
      owner_q     <= '0;
      address_q   <= '0;
    end else begin
      sys_gnt_q   <= 1'b0;
      data_gnt_q  <= 1'b0;
      fetch_gnt_q <= 1'b0;
      done_q      <= 1'b0;
      if (wd_hit) begin
        err_q      <= 1'b1;
        load_pc_q  <= 1'b0;
        load_dp_q  <= 1'b0;
        dp_write_q <= 1'b0;
        config_q   <= 1'b0;
        reset_q    <= 1'b0;
        owner_q    <= '0;
        state_q    <= IDLE;
      end else if (tick) begin
        case (state_q)
          IDLE: begin
            addr_cnt_q <= '0;
            if (i_sys_req) begin
              sys_gnt_q <= 1'b1;
              owner_q   <= 2'd3;
              address_q <= i_sys_addr;
              config_q  <= i_sys_op;
              reset_q   <= !i_sys_op;
              state_q   <= i_sys_op ? ADDR : RESTORE;
            end else if (i_data_req) begin
              data_gnt_q <= 1'b1;
              owner_q    <= 2'd2;
              address_q  <= i_data_addr;
              len_q      <= i_data_len;
              we_q       <= i_data_we;
              load_dp_q  <= 1'b1;
              state_q    <= ADDR;
            end else if (i_fetch_req) begin
              fetch_gnt_q <= 1'b1;
              owner_q     <= 2'd1;
              address_q   <= i_fetch_addr;
              load_pc_q   <= 1'b1;
              state_q     <= ADDR;
            end
          end
          ADDR: begin
            addr_cnt_q <= addr_cnt_q + 1'b1;
            if (addr_cnt_q == 3'd4) begin
              if (owner_q == 2'd1) begin
                load_pc_q <= 1'b0;
                owner_q   <= '0;
                state_q   <= IDLE;
              end else if (owner_q == 2'd2) begin
                xfer_cnt_q <= '0;
                dp_write_q <= we_q;
                state_q    <= XFER;
              end else state_q <= RESTORE;
            end
          end
          XFER: begin
            if (xfer_cnt_q == len_q) begin
              done_q     <= 1'b1;
              load_dp_q  <= 1'b0;
              dp_write_q <= 1'b0;
              state_q    <= RESTORE;
            end else xfer_cnt_q <= xfer_cnt_q + 1'b1;
          end
          RESTORE: begin
            if (!i_stalled_by_bus) begin
              load_pc_q  <= 1'b0;
              load_dp_q  <= 1'b0;
              dp_write_q <= 1'b0;
              config_q   <= 1'b0;
              reset_q    <= 1'b0;
              owner_q    <= '0;
              state_q    <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign o_sys_gnt      = sys_gnt_q;
  assign o_data_gnt     = data_gnt_q;
  assign o_fetch_gnt    = fetch_gnt_q;
  assign o_data_done    = done_q;
  assign o_address      = address_q;
  assign o_load_pc      = load_pc_q;
  assign o_cmd_load_dp  = load_dp_q;
  assign o_cmd_dp_write = dp_write_q;
  assign o_cmd_config   = config_q;
  assign o_cmd_reset    = reset_q;
  assign o_busy         = state_q != IDLE;
  assign o_owner        = owner_q;
  assign o_err          = err_q;
endmodule

// File: tb/tb_saturn_bus_arbiter.sv
// tb_saturn_bus_arbiter: directed plus random stimulus checked against a transaction-timeline model.
module tb_saturn_bus_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic en, stl, sbb, sys_req, sys_op, data_req, data_we, fetch_req;
  logic [19:0] sys_addr, data_addr, fetch_addr;
  logic [3:0] data_len;
  logic sys_gnt, data_gnt, data_done, fetch_gnt, load_pc, load_dp, dp_write, cfg, cmd_rst, busy, err;
  logic [19:0] address;
  logic [1:0] owner;
  int asserts = 0, fails = 0;
  // model: kind 0 none, 1 fetch, 2 data, 3 config, 4 reset; t = ticks since grant
  int m_kind = 0, m_t = 0;
  bit m_rest = 0, m_we = 0, e_sg = 0, e_dg = 0, e_fg = 0, e_done = 0;
  logic [19:0] m_addr = '0;
  logic [3:0] m_len = '0;
  int gnt_seq[$];
  always #5 clk = ~clk;
  saturn_bus_arbiter dut (
    .i_clk(clk), .i_reset(rst), .i_en_bus_ecmd(en), .i_stalled(stl), .i_stalled_by_bus(sbb),
    .i_sys_req(sys_req), .i_sys_op(sys_op), .i_sys_addr(sys_addr), .o_sys_gnt(sys_gnt),
    .i_data_req(data_req), .i_data_we(data_we), .i_data_addr(data_addr), .i_data_len(data_len),
    .o_data_gnt(data_gnt), .o_data_done(data_done), .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
    .o_fetch_gnt(fetch_gnt), .o_address(address), .o_load_pc(load_pc), .o_cmd_load_dp(load_dp),
    .o_cmd_dp_write(dp_write), .o_cmd_config(cfg), .o_cmd_reset(cmd_rst), .o_busy(busy),
    .o_owner(owner), .o_err(err));
  task automatic model_tick();
    e_sg = 0; e_dg = 0; e_fg = 0; e_done = 0;
    if (rst) begin
      m_kind = 0; m_t = 0; m_rest = 0; m_addr = '0;
    end else if (en && !stl) begin
      if (m_kind == 0) begin
        m_t = 0; m_rest = 0;
        if (sys_req) begin
          m_kind = sys_op ? 3 : 4; m_addr = sys_addr; m_rest = !sys_op; e_sg = 1;
        end else if (data_req) begin
          m_kind = 2; m_addr = data_addr; m_len = data_len; m_we = data_we; e_dg = 1;
        end else if (fetch_req) begin
          m_kind = 1; m_addr = fetch_addr; e_fg = 1;
        end
        if (m_kind != 0) gnt_seq.push_back(m_kind >= 3 ? 3 : m_kind);
      end else if (m_rest) begin
        if (!sbb) begin m_kind = 0; m_rest = 0; end
      end else begin
        m_t++;
        if (m_kind == 1 && m_t == 5) m_kind = 0;
        else if (m_kind == 3 && m_t == 5) m_rest = 1;
        else if (m_kind == 2 && m_t == 6 + int'(m_len)) begin m_rest = 1; e_done = 1; end
      end
    end
  endtask
  task automatic check();
    logic [9:0] exp_lv;
    bit ldp;
    ldp = m_kind == 2 && !m_rest;
    exp_lv = {m_kind == 1, ldp, ldp && m_we && m_t >= 5, m_kind == 3, m_kind == 4, m_kind != 0,
              2'(m_kind >= 3 ? 3 : m_kind), 1'b0};
    asserts++;
    assert ({sys_gnt, data_gnt, fetch_gnt, data_done} === {e_sg, e_dg, e_fg, e_done})
      else begin fails++; $error("FAIL pulses got %b exp %b", {sys_gnt, data_gnt, fetch_gnt, data_done}, {e_sg, e_dg, e_fg, e_done}); end
    asserts++;
    assert ({load_pc, load_dp, dp_write, cfg, cmd_rst, busy, owner, err} === exp_lv)
      else begin fails++; $error("FAIL levels got %b exp %b", {load_pc, load_dp, dp_write, cfg, cmd_rst, busy, owner, err}, exp_lv); end
    asserts++;
    assert (address === m_addr)
      else begin fails++; $error("FAIL address got %h exp %h", address, m_addr); end
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_tick();
      @(negedge clk);
      check();
    end
  endtask
  initial begin
    en = 0; stl = 0; sbb = 0; sys_req = 0; sys_op = 0; data_req = 0; data_we = 0; fetch_req = 0;
    sys_addr = '0; data_addr = '0; fetch_addr = '0; data_len = '0;
    step(3);
    rst = 0; en = 1;
    step(2);
    // fetch redirect
    fetch_req = 1; fetch_addr = 20'h12345;
    step(1);
    fetch_req = 0; fetch_addr = 20'hFFFFF;
    step(7);
    // data write with bus stall held in RESTORE
    data_req = 1; data_we = 1; data_addr = 20'h80000; data_len = 4'd3; sbb = 1;
    step(1);
    data_req = 0; data_len = 4'd9; data_addr = 20'h0;
    step(14);
    sbb = 0;
    step(2);
    // simultaneous requests: sys (configure), data, fetch
    gnt_seq.delete();
    sys_req = 1; sys_op = 1; sys_addr = 20'hABCDE; data_req = 1; data_we = 0; data_len = 4'd1;
    data_addr = 20'h00042; fetch_req = 1; fetch_addr = 20'h54321;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (e_sg) sys_req = 0;
      if (e_dg) data_req = 0;
      if (e_fg) fetch_req = 0;
    end
    asserts++;
    assert (gnt_seq.size() == 3 && gnt_seq[0] == 3 && gnt_seq[1] == 2 && gnt_seq[2] == 1)
      else begin fails++; $error("FAIL grant_order got %0d grants exp 3,2,1", gnt_seq.size()); end
    asserts++;
    assert (gnt_seq.size() == 3 && owner === 2'd0) else begin fails++; $error("FAIL idle_after_order got %0d exp 0", owner); end
    // global stall during address phase
    data_req = 1; data_we = 0; data_addr = 20'h31337; data_len = 4'd2;
    step(3);
    data_req = 0; stl = 1;
    step(10);
    stl = 0;
    step(12);
    // reset issued mid-transfer
    data_req = 1; data_we = 1; data_addr = 20'h0BEEF; data_len = 4'd5;
    step(1);
    data_req = 0;
    step(7);
    #1 rst = 1;
    #1;
    asserts++;
    assert ({sys_gnt, data_gnt, fetch_gnt, data_done, load_pc, load_dp, dp_write, cfg, cmd_rst, busy, owner, err, address} === '0)
      else begin fails++; $error("FAIL async_reset got %h exp 0", {sys_gnt, data_gnt, fetch_gnt, data_done, load_pc, load_dp, dp_write, cfg, cmd_rst, busy, owner, err, address}); end
    step(3);
    rst = 0;
    step(1);
    // reset op and full-length read
    sys_req = 1; sys_op = 0; sys_addr = 20'h11111;
    step(1);
    sys_req = 0;
    step(3);
    data_req = 1; data_we = 0; data_addr = 20'h77777; data_len = 4'hF;
    step(1);
    data_req = 0;
    step(25);
    // random traffic
    for (int i = 0; i < 2500; i++) begin
      en = $urandom_range(0, 3) != 0;
      stl = $urandom_range(0, 4) == 0;
      sbb = $urandom_range(0, 1) == 1;
      sys_req = $urandom_range(0, 9) == 0;
      sys_op = 1'($urandom);
      sys_addr = 20'($urandom);
      data_req = $urandom_range(0, 2) == 0;
      data_we = 1'($urandom);
      data_addr = 20'($urandom);
      data_len = 4'($urandom);
      fetch_req = $urandom_range(0, 2) == 0;
      fetch_addr = 20'($urandom);
      rst = $urandom_range(0, 499) == 0;
      step(1);
    end
    rst = 0;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
